axi_lite_ram_slave: RTL and testbench

AXI_LITE_RAM_SLAVE -- requirements
Module: axi_lite_ram_slave

---
 rtl/axi_lite_ram_slave_if.sv | 50 +++++
 rtl/axi_lite_ram_slave.sv | 193 +++++++++++++++++++
 tb/tb_axi_lite_ram_slave.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_ram_slave_if.sv
// AXI_ift: AXI-lite bus bundle shared by the RAM responder and its bench.
//
// Handshake rule for every channel: a transfer happens on the rising clock
// edge where both valid and ready are 1. The source keeps valid and its
// payload stable until that edge, and never makes valid depend on ready.
//
// Parameters
//   ADDR_WIDTH : width of awaddr/araddr
//   DATA_WIDTH : width of wdata/rdata; wstrb is DATA_WIDTH/8 bits
// Signal groups
//   Mw : awaddr, awvalid, wdata, wstrb, wvalid, bready   (master -> slave)
//   Sw : awready, wready, bresp, bvalid                  (slave -> master)
//   Mr : araddr, arvalid, rready                         (master -> slave)
//   Sr : arready, rdata, rresp, rvalid                   (slave -> master)
interface AXI_ift #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport Slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );

    modport Master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_ram_slave.sv
// axi_lite_ram_slave: AXI-lite responder backed by a word-organised RAM.
//
// Serves MEM_DEPTH words of AXI_DATA_WIDTH bits starting at byte address
// MEM_BEGIN. Aligned in-range accesses answer OKAY, misaligned in-range
// accesses answer SLVERR (no write, read data 0), anything outside the
// window answers DECERR. Write and read paths are independent FSMs.
// Read data appears READ_LATENCY cycles after the AR handshake.
//
// Ports
//   clk         : clock, rising edge
//   rstn        : asynchronous active-low reset (RAM contents are kept)
//   slave       : AXI_ift.Slave bus end; its widths must match the
//                 AXI_ADDR_WIDTH / AXI_DATA_WIDTH parameters
//   write_state : debug view of the write FSM (0 idle, 1 response)
//   read_state  : debug view of the read FSM (0 idle, 1 wait, 2 response)
module axi_lite_ram_slave #(
    parameter int          AXI_ADDR_WIDTH = 64,
    parameter int          AXI_DATA_WIDTH = 64,
    parameter logic [63:0] MEM_BEGIN      = 64'h8000_0000,
    parameter int          MEM_DEPTH      = 1024,
    parameter int          READ_LATENCY   = 1
) (
    input  logic         clk,
    input  logic         rstn,
    AXI_ift.Slave        slave,
    output logic         write_state,
    output logic [1:0]   read_state
);
    localparam int STRB_W   = AXI_DATA_WIDTH / 8;
    localparam int OFF_BITS = $clog2(STRB_W);
    localparam int IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [AXI_ADDR_WIDTH-1:0] BASE       = AXI_ADDR_WIDTH'(MEM_BEGIN);
    localparam logic [AXI_ADDR_WIDTH-1:0] DEPTH_A    = AXI_ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = AXI_ADDR_WIDTH'(STRB_W - 1);
    localparam logic [3:0]                LAT_M1     = 4'(READ_LATENCY - 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic       {W_IDLE, W_RESP}         w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

    // Range is decided before alignment: a misaligned address outside the
    // window is a decode error, not a slave error.
    function automatic logic [1:0] classify(input logic [AXI_ADDR_WIDTH-1:0] addr);
        logic [AXI_ADDR_WIDTH-1:0] off;
        off = addr - BASE;
        if (addr < BASE)
            return RESP_DECERR;
        if ((off >> OFF_BITS) >= DEPTH_A)
            return RESP_DECERR;
        if ((off & ALIGN_MASK) != '0)
            return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    function automatic logic [IDX_W-1:0] word_index(input logic [AXI_ADDR_WIDTH-1:0] addr);
        return IDX_W'((addr - BASE) >> OFF_BITS);
    endfunction

    logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    w_state_t   w_state;
    logic [1:0] bresp_q;
    logic [1:0] w_code;
    logic       aw_hs;

    // AW and W are only taken together; rstn gating keeps the readies low
    // while reset is held, even if the master is already presenting valids.
    assign aw_hs  = rstn && (w_state == W_IDLE) && slave.awvalid && slave.wvalid;
    assign w_code = classify(slave.awaddr);

    assign slave.awready = aw_hs;
    assign slave.wready  = aw_hs;
    assign slave.bvalid  = (w_state == W_RESP);
    assign slave.bresp   = bresp_q;
    assign write_state   = w_state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state <= W_IDLE;
            bresp_q <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        bresp_q <= w_code;
                        w_state <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (slave.bready)
                        w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // RAM is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (aw_hs && (w_code == RESP_OKAY)) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (slave.wstrb[b])
                    mem[word_index(slave.awaddr)][b*8 +: 8] <= slave.wdata[b*8 +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    r_state_t                  r_state;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr_q;
    logic [1:0]                ar_code_q;
    logic [3:0]                cnt;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;
    logic [1:0]                rresp_q;
    logic                      ar_hs;
    logic [1:0]                r_code;
    logic [AXI_ADDR_WIDTH-1:0] rd_addr;
    logic [1:0]                rd_code;
    logic [AXI_DATA_WIDTH-1:0] rd_word;

    assign ar_hs  = rstn && (r_state == R_IDLE) && slave.arvalid;
    assign r_code = classify(slave.araddr);

    // With a latency of one the load happens on the handshake edge itself,
    // so the address comes straight off the bus; otherwise from the latch.
    always_comb begin
        rd_addr = ar_addr_q;
        rd_code = ar_code_q;
        if (r_state == R_IDLE) begin
            rd_addr = slave.araddr;
            rd_code = r_code;
        end
        rd_word = mem[word_index(rd_addr)];
    end

    assign slave.arready = ar_hs;
    assign slave.rvalid  = (r_state == R_RESP);
    assign slave.rdata   = rdata_q;
    assign slave.rresp   = rresp_q;
    assign read_state    = r_state;

    // rdata_q samples the RAM with a non-blocking read, so a write landing
    // on the same edge is not visible: the pre-write word is returned.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= R_IDLE;
            ar_addr_q <= '0;
            ar_code_q <= RESP_OKAY;
            cnt       <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        ar_addr_q <= slave.araddr;
                        ar_code_q <= r_code;
                        cnt       <= LAT_M1;
                        if (READ_LATENCY == 1) begin
                            rdata_q <= (rd_code == RESP_OKAY) ? rd_word : '0;
                            rresp_q <= rd_code;
                            r_state <= R_RESP;
                        end else begin
                            r_state <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        rdata_q <= (rd_code == RESP_OKAY) ? rd_word : '0;
                        rresp_q <= rd_code;
                        r_state <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (slave.rready)
                        r_state <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_ram_slave.sv
module tb_axi_lite_ram_slave;
    localparam int          LAT   = 3;
    localparam int          DEPTH = 1024;
    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          NWORD = 16;   // words exercised by the bench

    // ---------------- clock / reset ----------------
    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic       write_state;
    logic [1:0] read_state;

    always #5 clk = ~clk;

    AXI_ift #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();

    axi_lite_ram_slave #(
        .AXI_ADDR_WIDTH(64),
        .AXI_DATA_WIDTH(64),
        .MEM_BEGIN     (BASE),
        .MEM_DEPTH     (DEPTH),
        .READ_LATENCY  (LAT)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .slave      (bus),
        .write_state(write_state),
        .read_state (read_state)
    );

    // ---------------- reference model / scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [63:0] model_mem [NWORD];
    logic [63:0] exp_q [$];

    function automatic logic [1:0] model_resp(input logic [63:0] a);
        if (a < BASE || a >= BASE + 64'(DEPTH) * 64'd8)
            return 2'b11;
        if (a % 64'd8 != 64'd0)
            return 2'b10;
        return 2'b00;
    endfunction

    function automatic int model_idx(input logic [63:0] a);
        return int'((a - BASE) / 64'd8);
    endfunction

    task automatic model_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
        int i;
        if (model_resp(a) != 2'b00)
            return;
        i = model_idx(a);
        for (int b = 0; b < 8; b++)
            if (s[b])
                model_mem[i][b*8 +: 8] = d[b*8 +: 8];
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic axi_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
        logic [1:0] er;
        er = model_resp(a);
        @(negedge clk);
        bus.awaddr  = a;
        bus.wdata   = d;
        bus.wstrb   = s;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        bus.bready  = 1'b1;
        #1;
        chk("awready", 64'(bus.awready), 64'd1);
        chk("wready", 64'(bus.wready), 64'd1);
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        #1;
        chk("bvalid_rise", 64'(bus.bvalid), 64'd1);
        chk("bresp", 64'(bus.bresp), 64'(er));
        model_write(a, d, s);
        @(negedge clk);
        #1;
        chk("bvalid_drop", 64'(bus.bvalid), 64'd0);
    endtask

    task automatic axi_read(input logic [63:0] a, input int hold);
        logic [1:0]  er;
        logic [63:0] ed;
        logic [63:0] first;
        int          n;
        bit          got;
        er = model_resp(a);
        ed = (er == 2'b00) ? model_mem[model_idx(a)] : 64'd0;
        exp_q.push_back(ed);
        @(negedge clk);
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        bus.rready  = (hold == 0);
        #1;
        chk("arready", 64'(bus.arready), 64'd1);
        n   = 0;
        got = 1'b0;
        while (n < 20 && !got) begin
            @(negedge clk);
            bus.arvalid = 1'b0;
            n++;
            #1;
            if (bus.rvalid)
                got = 1'b1;
        end
        chk("r_latency", 64'(n), 64'(LAT));
        chk("rresp", 64'(bus.rresp), 64'(er));
        first = exp_q.pop_front();
        chk("rdata", bus.rdata, first);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1;
            chk("rvalid_hold", 64'(bus.rvalid), 64'd1);
            chk("rdata_hold", bus.rdata, first);
        end
        bus.rready = 1'b1;
        @(negedge clk);
        #1;
        chk("rvalid_drop", 64'(bus.rvalid), 64'd0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [63:0] a;
        logic [63:0] d;
        logic [63:0] old;
        logic [7:0]  s;
        int          sel;

        bus.awaddr  = '0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.awvalid = 1'b1;   // valids high during reset must not be accepted
        bus.wvalid  = 1'b1;
        bus.bready  = 1'b0;
        bus.araddr  = BASE;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b0;

        #12;
        chk("rst_awready", 64'(bus.awready), 64'd0);
        chk("rst_wready", 64'(bus.wready), 64'd0);
        chk("rst_arready", 64'(bus.arready), 64'd0);
        chk("rst_bvalid", 64'(bus.bvalid), 64'd0);
        chk("rst_bresp", 64'(bus.bresp), 64'd0);
        chk("rst_rvalid", 64'(bus.rvalid), 64'd0);
        chk("rst_rdata", bus.rdata, 64'd0);
        chk("rst_rresp", 64'(bus.rresp), 64'd0);
        chk("rst_wstate", 64'(write_state), 64'd0);
        chk("rst_rstate", 64'(read_state), 64'd0);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.arvalid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;

        // Known contents for the exercised words.
        for (int w = 0; w < NWORD; w++)
            axi_write(BASE + 64'(w) * 64'd8, {$urandom, $urandom}, 8'hFF);

        // Full write then read-back with latency 3.
        axi_write(64'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF);
        axi_read(64'h8000_0008, 0);

        // Partial strobe.
        axi_write(64'h8000_0008, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
        chk("strobe_model", model_mem[1], 64'h1122_3344_AAAA_AAAA);
        axi_read(64'h8000_0008, 0);

        // Misaligned write leaves memory untouched; outside reads decode-error.
        axi_write(64'h8000_0004, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
        axi_read(64'h8000_0000, 0);
        axi_read(64'h8000_0008, 0);
        axi_read(64'h0000_1000, 0);
        axi_read(BASE + 64'(DEPTH) * 64'd8, 0);      // first word past the end
        axi_read(BASE + 64'(DEPTH - 1) * 64'd8 + 64'd3, 0);  // last word, misaligned

        // AW without W: nothing accepted until both are valid.
        @(negedge clk);
        bus.awaddr  = BASE + 64'd16;
        bus.wdata   = 64'h0102_0304_0506_0708;
        bus.wstrb   = 8'hFF;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("aw_only_awready", 64'(bus.awready), 64'd0);
            chk("aw_only_wready", 64'(bus.wready), 64'd0);
            @(negedge clk);
        end
        bus.wvalid = 1'b1;
        #1;
        chk("both_awready", 64'(bus.awready), 64'd1);
        chk("both_wready", 64'(bus.wready), 64'd1);
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        #1;
        chk("late_w_bvalid", 64'(bus.bvalid), 64'd1);
        chk("late_w_bresp", 64'(bus.bresp), 64'd0);
        model_write(BASE + 64'd16, 64'h0102_0304_0506_0708, 8'hFF);
        @(negedge clk);
        #1;
        chk("late_w_bdrop", 64'(bus.bvalid), 64'd0);

        // Read held off by rready=0 for 4 cycles.
        axi_read(BASE + 64'd16, 4);

        // Write landing on the same edge the read loads data: old data returned.
        old = model_mem[5];
        @(negedge clk);
        bus.araddr  = BASE + 64'd40;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b1;
        #1;
        chk("coll_arready", 64'(bus.arready), 64'd1);
        @(negedge clk);
        bus.arvalid = 1'b0;
        @(negedge clk);
        bus.awaddr  = BASE + 64'd40;
        bus.wdata   = 64'hC0FF_EE00_C0FF_EE00;
        bus.wstrb   = 8'hFF;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        bus.bready  = 1'b1;
        #1;
        chk("coll_awready", 64'(bus.awready), 64'd1);
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        #1;
        chk("coll_rvalid", 64'(bus.rvalid), 64'd1);
        chk("coll_rdata_old", bus.rdata, old);
        chk("coll_bvalid", 64'(bus.bvalid), 64'd1);
        model_write(BASE + 64'd40, 64'hC0FF_EE00_C0FF_EE00, 8'hFF);
        @(negedge clk);
        #1;
        chk("coll_rdrop", 64'(bus.rvalid), 64'd0);
        axi_read(BASE + 64'd40, 0);

        // Reset while a write response is pending.
        @(negedge clk);
        bus.awaddr  = BASE + 64'd24;
        bus.wdata   = 64'h5A5A_0000_FFFF_1234;
        bus.wstrb   = 8'hFF;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        bus.bready  = 1'b0;
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        model_write(BASE + 64'd24, 64'h5A5A_0000_FFFF_1234, 8'hFF);
        #1;
        chk("pend_bvalid", 64'(bus.bvalid), 64'd1);
        @(negedge clk);
        #1;
        chk("pend_bvalid_held", 64'(bus.bvalid), 64'd1);
        #1;
        rstn = 1'b0;
        #1;
        chk("midrst_bvalid", 64'(bus.bvalid), 64'd0);
        chk("midrst_wstate", 64'(write_state), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        axi_read(BASE + 64'd24, 0);
        axi_read(BASE + 64'd8, 1);

        // Random mix against the model.
        for (int it = 0; it < 60; it++) begin
            sel = $urandom_range(0, 9);
            a   = BASE + 64'($urandom_range(0, NWORD - 1)) * 64'd8;
            if (sel == 8)
                a = a + 64'($urandom_range(1, 7));
            else if (sel == 9)
                a = ($urandom_range(0, 1) == 0)
                    ? BASE - 64'($urandom_range(1, 4)) * 64'd8
                    : BASE + 64'(DEPTH) * 64'd8 + 64'($urandom_range(0, 4)) * 64'd8;
            if ($urandom_range(0, 1) == 0) begin
                d = {$urandom, $urandom};
                s = 8'($urandom_range(0, 255));
                axi_write(a, d, s);
            end else begin
                axi_read(a, $urandom_range(0, 2));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
